// File: rtl/bcd_serial_adder_ctrl.sv
// Packed-BCD adder that reuses one digit slice, LSD first.
// One digit per cycle; result and flags held until next start.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W = 4 * DIGITS;
    localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            err_q;
    logic            busy_q;
    logic            done_q;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [4:0] slice_t;
    logic [3:0] slice_dig;
    logic       slice_cy;
    logic       bad_in;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = b_q[4*i +: 4];
            end
        end
    end

    // Decimal correction: add 6 and keep low nibble when t exceeds 9.
    always_comb begin
        slice_t = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, carry_q};
        if (slice_t > 5'd9) begin
            slice_dig = slice_t[3:0] + 4'd6;
            slice_cy  = 1'b1;
        end else begin
            slice_dig = slice_t[3:0];
            slice_cy  = 1'b0;
        end
    end

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                bad_in = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        err_q   <= bad_in;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IDXW'(i)) begin
                            sum_q[4*i +: 4] <= slice_dig;
                        end
                    end
                    carry_q <= slice_cy;
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == LAST) begin
                        cout_q  <= slice_cy;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench: drivers push expected results,
// negedge monitors pop and compare on each done pulse.
module tb_bcd_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start4, cin4, busy4, done4, cout4, err4;
    logic [15:0] a4, b4, sum4;
    logic        start1, cin1, busy1, done1, cout1, err1;
    logic [3:0]  a1, b1, sum1;

    bcd_serial_adder_ctrl #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4),
        .cout(cout4), .err(err4)
    );

    bcd_serial_adder_ctrl #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .err(err1)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    int bc4 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bc4 = 0;
        end else begin
            if (busy4) bc4++;
            if (done4) begin
                if (q4.size() == 0) begin
                    chk("done4_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("sum4", {16'b0, sum4}, {16'b0, e.sum});
                    chk("cout4", {31'b0, cout4}, {31'b0, e.cout});
                    chk("err4", {31'b0, err4}, {31'b0, e.err});
                    chk("lat4", cyc - e.acc, 32'd4);
                    chk("busycnt4", bc4, 32'd4);
                    chk("busy4_at_done", {31'b0, busy4}, 32'd0);
                end
                bc4 = 0;
            end
        end
    end

    int bc1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bc1 = 0;
        end else begin
            if (busy1) bc1++;
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("sum1", {28'b0, sum1}, {16'b0, e.sum});
                    chk("cout1", {31'b0, cout1}, {31'b0, e.cout});
                    chk("err1", {31'b0, err1}, {31'b0, e.err});
                    chk("lat1", cyc - e.acc, 32'd1);
                    chk("busycnt1", bc1, 32'd1);
                end
                bc1 = 0;
            end
        end
    end

    // Called at posedge+1; leaves at posedge+1 ready for next op.
    task automatic op4(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] s,
                       input logic co, input logic er);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge clk); #1;
        q4.push_back('{s, co, er, cyc});
        start4 = 1'b0;
        a4 = 16'hFFFF; b4 = 16'hFFFF; cin4 = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] s,
                       input logic co, input logic er);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(posedge clk); #1;
        q1.push_back('{{12'b0, s}, co, er, cyc});
        start1 = 1'b0;
        a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    logic [15:0] ha[7];
    logic [15:0] hb[7];

    initial begin
        rst = 1'b1;
        start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
        start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum4", {16'b0, sum4}, 32'd0);
        chk("rst_flags4", {28'b0, busy4, done4, cout4, err4}, 32'd0);
        chk("rst_sum1", {28'b0, sum1}, 32'd0);
        chk("rst_flags1", {28'b0, busy1, done1, cout1, err1}, 32'd0);
        rst = 1'b0;

        op4(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        op4(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4(16'h5555, 16'h4444, 1'b1, 16'h0000, 1'b1, 1'b0);
        op4(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op4(16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b1);
        op4(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // start held high; only k=0 and k=6 may be accepted
        ha[0] = 16'h1111; hb[0] = 16'h2222;
        ha[1] = 16'h8765; hb[1] = 16'h4321;
        ha[2] = 16'h9999; hb[2] = 16'h9999;
        ha[3] = 16'h0101; hb[3] = 16'h7070;
        ha[4] = 16'h4444; hb[4] = 16'h3333;
        ha[5] = 16'h9000; hb[5] = 16'h1000;
        ha[6] = 16'h0500; hb[6] = 16'h0505;
        start4 = 1'b1; cin4 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            a4 = ha[k]; b4 = hb[k];
            @(posedge clk); #1;
            if (k == 0) q4.push_back('{16'h3333, 1'b0, 1'b0, cyc});
            if (k == 6) q4.push_back('{16'h1005, 1'b0, 1'b0, cyc});
        end
        start4 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end

        // reset on the second ADD cycle aborts the op
        a4 = 16'h0999; b4 = 16'h000A; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_sum4", {16'b0, sum4}, 32'd0);
        chk("abort_flags4", {28'b0, busy4, done4, cout4, err4}, 32'd0);
        repeat (6) begin @(posedge clk); #1; end
        op4(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

        op1(4'h9, 4'h9, 1'b1, 4'h9, 1'b1, 1'b0);
        op1(4'h4, 4'h3, 1'b0, 4'h7, 1'b0, 1'b0);
        op1(4'hB, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1);

        repeat (4) begin @(posedge clk); #1; end
        while (q4.size() > 0) begin
            void'(q4.pop_front());
            chk("done4_missing", 32'd0, 32'd1);
        end
        while (q1.size() > 0) begin
            void'(q1.pop_front());
            chk("done1_missing", 32'd0, 32'd1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
